// File: rtl/ram_dp_be.sv
// ram_dp_be: simple dual-port RAM (1W/1R, one clock) with byte enables,
// write-first same-address bypass, optional output register and clear sweep.
`default_nettype none

module ram_dp_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 6,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH/8-1:0] wmask,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    rvalid,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("ram_dp_be: DATA_WIDTH must be a multiple of 8");
  end

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [NB-1:0]           wr_mask;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_acc;
  logic [NB-1:0]           byp_now;

  logic [DATA_WIDTH-1:0]   mem_q;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [NB-1:0]           byp_q;
  logic                    rvalid_s1;
  logic [DATA_WIDTH-1:0]   merged;

  // ---------------- clear-sweep FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST_ADDR) begin
        state_nxt = ST_READY;
      end
    end
  end

  assign busy = (state == ST_CLEAR);

  // ---------------- write port ----------------
  // The sweep shares the single write port; user writes are locked out meanwhile.
  assign wr_en   = rst_n & (busy | we);
  assign wr_addr = busy ? clr_cnt : waddr;
  assign wr_mask = busy ? {NB{1'b1}} : wmask;
  assign wr_data = busy ? {DATA_WIDTH{1'b0}} : din;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // ---------------- read port ----------------
  assign rd_acc  = rst_n & ~busy & re;
  assign byp_now = (we && (waddr == raddr)) ? wmask : {NB{1'b0}};

  always_ff @(posedge clk) begin
    if (rd_acc) begin
      mem_q <= mem[raddr];
    end
  end

  // Reset forces every byte onto the bypass path with zero data, so dout reads
  // 0 without needing a reset on the RAM output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q     <= '0;
      byp_q     <= {NB{1'b1}};
      rvalid_s1 <= 1'b0;
    end else begin
      rvalid_s1 <= rd_acc;
      if (rd_acc) begin
        din_q <= din;
        byp_q <= byp_now;
      end
    end
  end

  for (genvar gb = 0; gb < NB; gb++) begin : g_byte
    assign merged[8*gb +: 8] = byp_q[gb] ? din_q[8*gb +: 8] : mem_q[8*gb +: 8];
  end

  // ---------------- optional output register ----------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  rvalid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q   <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rvalid_s1;
        if (rvalid_s1) begin
          dout_q <= merged;
        end
      end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;
  end else begin : g_no_out_reg
    assign dout   = merged;
    assign rvalid = rvalid_s1;
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_dp_be.sv
// tb_ram_dp_be: scoreboard bench driving an OUT_REG=0 and an OUT_REG=1 instance
// (ADDR_WIDTH=4, CLEAR_ON_RESET=1) with identical stimulus.
`default_nettype none

module tb_ram_dp_be;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  raddr = '0;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [3:0]  wmask = '0;
  logic [31:0] din = '0;

  logic [31:0] dout0, dout1;
  logic        rvalid0, rvalid1, busy0, busy1;

  always #5 clk = ~clk;

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .we(we), .waddr(waddr),
    .wmask(wmask), .din(din), .dout(dout0), .rvalid(rvalid0), .busy(busy0)
  );

  ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .re(re), .raddr(raddr), .we(we), .waddr(waddr),
    .wmask(wmask), .din(din), .dout(dout1), .rvalid(rvalid1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1;
  logic [31:0] model [16];
  logic [31:0] last0 = '0, last1 = '0;
  int          busy_left = 16;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // One clock of stimulus: the reference model predicts reads and applies writes.
  task automatic drive(input logic r, input logic [3:0] ra, input logic w,
                       input logic [3:0] wa, input logic [3:0] m, input logic [31:0] d);
    exp_t        e;
    logic [31:0] v;
    re = r; raddr = ra; we = w; waddr = wa; wmask = m; din = d;
    if (rst_n && busy_left == 0) begin
      if (r) begin
        v = model[ra];
        if (w && wa == ra)
          for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = d[8*b +: 8];
        e.data = v;
        e.cyc  = cyc + 1;
        q0.push_back(e);
        q1.push_back(e);
      end
      if (w)
        for (int b = 0; b < 4; b++) if (m[b]) model[wa][8*b +: 8] = d[8*b +: 8];
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      busy_left = 16;
      for (int i = 0; i < 16; i++) model[i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] m, input logic [31:0] d);
    drive(1'b0, 4'd0, 1'b1, a, m, d);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, a, 1'b0, 4'd0, 4'h0, 32'h0);
  endtask

  // Output monitors: valid data is popped and checked, idle cycles must hold dout.
  always @(negedge clk) begin
    if (!rst_n) begin
      last0 = dout0;
    end else if (rvalid0) begin
      checks++;
      if (q0.size() == 0) begin
        failures++;
        $display("FAIL rd0_unexpected dout=%h rvalid=1 required rvalid=0", dout0);
      end else begin
        e0 = q0.pop_front();
        if (dout0 !== e0.data || cyc != e0.cyc) begin
          failures++;
          $display("FAIL rd0_data dout=%h cyc=%0d required dout=%h cyc=%0d",
                   dout0, cyc, e0.data, e0.cyc);
        end
      end
      last0 = dout0;
    end else begin
      checks++;
      if (dout0 !== last0) begin
        failures++;
        $display("FAIL rd0_hold dout=%h required %h", dout0, last0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      last1 = dout1;
    end else if (rvalid1) begin
      checks++;
      if (q1.size() == 0) begin
        failures++;
        $display("FAIL rd1_unexpected dout=%h rvalid=1 required rvalid=0", dout1);
      end else begin
        e1 = q1.pop_front();
        if (dout1 !== e1.data || cyc != e1.cyc + 1) begin
          failures++;
          $display("FAIL rd1_data dout=%h cyc=%0d required dout=%h cyc=%0d",
                   dout1, cyc, e1.data, e1.cyc + 1);
        end
      end
      last1 = dout1;
    end else begin
      checks++;
      if (dout1 !== last1) begin
        failures++;
        $display("FAIL rd1_hold dout=%h required %h", dout1, last1);
      end
    end
  end

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      idle(1);
      n++;
    end
    checks++;
    if (n != 16 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_cycles=%0d busy1=%b required 16 and 0", name, n, busy1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy busy0=%b busy1=%b required 1", busy0, busy1);
    end
    checks++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || dout0 !== 32'h0 || dout1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_out rvalid=%b%b dout0=%h dout1=%h required 0", rvalid0, rvalid1, dout0, dout1);
    end
    rst_n = 1'b1;
    count_busy("sweep_len");
    for (int a = 0; a < 16; a++) rd(4'(a));
    idle(3);
  endtask

  task automatic test_reset_mid_sweep();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(9);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    count_busy("sweep_restart");
    idle(2);
  endtask

  task automatic test_busy_ignore();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'd2, 1'b1, 4'd2, 4'hF, 32'hFFFF_FFFF);
      checks++;
      if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || busy0 !== 1'b1) begin
        failures++;
        $display("FAIL busy_ignore rvalid=%b%b busy=%b required rvalid=00 busy=1",
                 rvalid0, rvalid1, busy0);
      end
    end
    idle(12);
    rd(4'd2);
    idle(3);
  endtask

  task automatic test_byte_mask();
    wr(4'd5, 4'hF, 32'hDEAD_BEEF);
    wr(4'd5, 4'b0101, 32'h1122_3344);
    rd(4'd5);
    wr(4'd5, 4'h0, 32'hFFFF_FFFF);
    rd(4'd5);
    wr(4'd6, 4'b0011, 32'hA5A5_C3C3);
    rd(4'd6);
    idle(3);
  endtask

  task automatic test_bypass();
    wr(4'd7, 4'hF, 32'h1234_5678);
    idle(1);
    drive(1'b1, 4'd7, 1'b1, 4'd7, 4'b1000, 32'hAA00_0000);
    rd(4'd7);
    wr(4'd8, 4'hF, 32'h0000_0055);
    drive(1'b1, 4'd8, 1'b1, 4'd9, 4'hF, 32'hCAFE_F00D);
    rd(4'd9);
    idle(3);
  endtask

  task automatic test_write_then_read();
    wr(4'd3, 4'hF, 32'h0BAD_F00D);
    rd(4'd3);
    wr(4'd15, 4'b1100, 32'h7788_9900);
    rd(4'd15);
    idle(3);
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 4; a++) wr(4'(a), 4'hF, 32'h10 + 32'(a));
    for (int a = 0; a < 4; a++) rd(4'(a));
    idle(4);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL pending_reads q0=%0d q1=%0d required 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sweep();
    test_busy_ignore();
    test_byte_mask();
    test_bypass();
    test_write_then_read();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
